// File: rtl/wb_unit_pkg.sv
// ---------------------------------------------------------------------------
// wb_unit_pkg -- shared core definitions for the write-back unit.
//   load_funct3_e : RISC-V load funct3 encodings (LB/LH/LW/LBU/LHU + reserved)
//   LDQ_DEPTH     : depth of the pending-load queue
//   ld_entry_t    : one pending load {rd, funct3, off}
//   is_legal_load : true for the five defined load encodings
//   rd_match      : register-address compare that never matches x0
// ---------------------------------------------------------------------------
package wb_unit_pkg;

    typedef enum logic [2:0] {
        F3_LB   = 3'b000,
        F3_LH   = 3'b001,
        F3_LW   = 3'b010,
        F3_RSV3 = 3'b011,
        F3_LBU  = 3'b100,
        F3_LHU  = 3'b101,
        F3_RSV6 = 3'b110,
        F3_RSV7 = 3'b111
    } load_funct3_e;

    localparam int LDQ_DEPTH = 2;

    typedef struct packed {
        logic [4:0]   rd;
        load_funct3_e funct3;
        logic [1:0]   off;
    } ld_entry_t;

    function automatic logic is_legal_load(input load_funct3_e f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic rd_match(input logic [4:0] rs, input logic [4:0] rd);
        return (rs != 5'd0) && (rs == rd);
    endfunction

endpackage

// File: rtl/wb_load_fmt.sv
// ---------------------------------------------------------------------------
// wb_load_fmt -- purely combinational load-data formatter.
//   funct3   in  3  load encoding (reserved encodings behave as LW)
//   off      in  2  byte offset within the word
//   rdata    in 32  raw memory word
//   data     out 32 shifted and sign/zero-extended result
//   misalign out 1  halfword at odd offset, or word at nonzero offset
// ---------------------------------------------------------------------------
module wb_load_fmt
    import wb_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] data,
    output logic        misalign
);

    logic [31:0] shifted;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can leave it unassigned (no latch).
    always_comb begin
        shifted  = rdata >> {off, 3'b000};
        data     = shifted;
        misalign = 1'b0;
        case (load_funct3_e'(funct3))
            F3_LB:  data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH: begin
                data     = {{16{shifted[15]}}, shifted[15:0]};
                misalign = off[0];
            end
            F3_LBU: data = {24'd0, shifted[7:0]};
            F3_LHU: begin
                data     = {16'd0, shifted[15:0]};
                misalign = off[0];
            end
            default: begin
                // LW and the reserved encodings
                data     = shifted;
                misalign = (off != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// ---------------------------------------------------------------------------
// wb_unit -- register-file write-back arbiter for ALU results and loads.
//   clock, rstn                     sole clock / async active-low reset
//   alu_valid/ready/rd/data         ALU result handshake (1-entry skid)
//   ld_issue/rd/funct3/off, ld_full load issued to memory, 2-deep queue
//   mem_rvalid/rdata                in-order memory responses
//   rf_wen/rf_rdaddr/rf_wdata       registered register-file write port
//   rs1_addr/rs2_addr, hazard       RAW hazard query against pending writes
//   err                             sticky protocol error
// Optional feature macro WB_FWD_EN: adds fwd_rs1_hit / fwd_rs2_hit, which flag
// that the consumer may take rf_wdata; without it the rf write stage itself
// is included in the hazard check.
// ---------------------------------------------------------------------------
module wb_unit
    import wb_unit_pkg::*;
(
    input  logic        clock,
    input  logic        rstn,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_issue,
    input  logic [4:0]  ld_rd,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    output logic        ld_full,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rf_wen,
    output logic [4:0]  rf_rdaddr,
    output logic [31:0] rf_wdata,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        hazard,
    output logic        err
`ifdef WB_FWD_EN
   ,output logic        fwd_rs1_hit,
    output logic        fwd_rs2_hit
`endif
);

    logic [1:0]  count;
    ld_entry_t   q [LDQ_DEPTH];
    logic        skid_valid;
    logic [4:0]  skid_rd;
    logic [31:0] skid_data;

    logic        push, pop, alu_accept, push_idx;
    logic [31:0] ld_data;
    logic        ld_misalign, ld_bad, err_set;
    logic        wr_en, skid_load, skid_drain;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;

    assign ld_full    = (count == 2'(LDQ_DEPTH));
    assign alu_ready  = !skid_valid;
    assign push       = ld_issue && !ld_full;
    assign pop        = mem_rvalid && (count != 2'd0);
    assign alu_accept = alu_valid && alu_ready;
    // Slot 1 is written only when one entry stays resident this cycle.
    assign push_idx   = (count == 2'd1) && !pop;

    wb_load_fmt u_fmt (
        .funct3   (q[0].funct3),
        .off      (q[0].off),
        .rdata    (mem_rdata),
        .data     (ld_data),
        .misalign (ld_misalign)
    );

    assign ld_bad  = ld_misalign || !is_legal_load(q[0].funct3);
    assign err_set = (ld_issue && ld_full) || (mem_rvalid && (count == 2'd0)) ||
                     (pop && ld_bad);

    // Single write slot: load response > skid drain > fresh ALU result.
    always_comb begin
        wr_en      = 1'b0;
        wr_rd      = 5'd0;
        wr_data    = 32'd0;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        if (pop) begin
            wr_en     = 1'b1;
            wr_rd     = q[0].rd;
            wr_data   = ld_data;
            skid_load = alu_accept;
        end else if (skid_valid) begin
            wr_en      = 1'b1;
            wr_rd      = skid_rd;
            wr_data    = skid_data;
            skid_drain = 1'b1;
        end else if (alu_accept) begin
            wr_en   = 1'b1;
            wr_rd   = alu_rd;
            wr_data = alu_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            count      <= 2'd0;
            skid_valid <= 1'b0;
            err        <= 1'b0;
            rf_wen     <= 1'b0;
            rf_rdaddr  <= 5'd0;
            rf_wdata   <= 32'd0;
        end else begin
            count <= count + 2'(push) - 2'(pop);
            if (skid_load)
                skid_valid <= 1'b1;
            else if (skid_drain)
                skid_valid <= 1'b0;
            if (err_set)
                err <= 1'b1;
            // x0 writes are consumed without touching the register file
            rf_wen <= wr_en && (wr_rd != 5'd0);
            if (wr_en && (wr_rd != 5'd0)) begin
                rf_rdaddr <= wr_rd;
                rf_wdata  <= wr_data;
            end
        end
    end

    // NOTE: payload storage is qualified by count/skid_valid, so it carries
    // no reset; only the valid tracking above is cleared.
    always_ff @(posedge clock) begin
        if (pop)
            q[0] <= q[1];
        if (push)
            q[push_idx] <= '{rd: ld_rd, funct3: load_funct3_e'(ld_funct3), off: ld_off};
        if (skid_load) begin
            skid_rd   <= alu_rd;
            skid_data <= alu_data;
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < LDQ_DEPTH; i++) begin
            if (count > 2'(i) &&
                (rd_match(rs1_addr, q[i].rd) || rd_match(rs2_addr, q[i].rd)))
                hazard = 1'b1;
        end
        if (skid_valid && (rd_match(rs1_addr, skid_rd) || rd_match(rs2_addr, skid_rd)))
            hazard = 1'b1;
`ifndef WB_FWD_EN
        if (rf_wen && (rd_match(rs1_addr, rf_rdaddr) || rd_match(rs2_addr, rf_rdaddr)))
            hazard = 1'b1;
`endif
    end

`ifdef WB_FWD_EN
    assign fwd_rs1_hit = rf_wen && rd_match(rs1_addr, rf_rdaddr);
    assign fwd_rs2_hit = rf_wen && rd_match(rs2_addr, rf_rdaddr);
`endif

endmodule

// File: tb/tb_wb_unit.sv
// ---------------------------------------------------------------------------
// tb_wb_unit -- self-checking bench for wb_unit: directed scenarios followed
// by randomized traffic compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_wb_unit;

    logic        clock = 1'b0;
    logic        rstn;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue, ld_full;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_off;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_wen;
    logic [4:0]  rf_rdaddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        hazard, err;
`ifdef WB_FWD_EN
    logic        fwd_rs1_hit, fwd_rs2_hit;
`endif

    always #5 clock = ~clock;

    wb_unit dut (
        .clock(clock), .rstn(rstn),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_off(ld_off),
        .ld_full(ld_full),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_wen(rf_wen), .rf_rdaddr(rf_rdaddr), .rf_wdata(rf_wdata),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .hazard(hazard), .err(err)
`ifdef WB_FWD_EN
       ,.fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned rd;
        int unsigned f3;
        int unsigned off;
    } pend_t;

    pend_t       ldq[$];
    int unsigned skq_rd[$];
    logic [31:0] skq_data[$];
    logic        m_wen, m_err;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    function automatic logic [31:0] fmt(input int unsigned f3, input int unsigned off,
                                        input logic [31:0] rdata, output bit bad);
        logic [31:0] sh, v;
        sh  = rdata >> (8 * off);
        bad = 1'b0;
        case (f3)
            0: begin v = sh & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256; end
            1: begin v = sh & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; bad = (off % 2) != 0; end
            4: v = sh & 32'hFF;
            5: begin v = sh & 32'hFFFF; bad = (off % 2) != 0; end
            2: begin v = sh; bad = (off != 0); end
            default: begin v = sh; bad = 1'b1; end
        endcase
        return v;
    endfunction

    function automatic bit hits(input int unsigned rd);
        return (rs1_addr != 0 && rs1_addr == rd) || (rs2_addr != 0 && rs2_addr == rd);
    endfunction

    function automatic bit m_hazard();
        bit h = 1'b0;
        foreach (ldq[i]) if (hits(ldq[i].rd)) h = 1'b1;
        foreach (skq_rd[i]) if (hits(skq_rd[i])) h = 1'b1;
`ifndef WB_FWD_EN
        if (m_wen && hits(m_addr)) h = 1'b1;
`endif
        return h;
    endfunction

    task automatic model_clear();
        ldq.delete(); skq_rd.delete(); skq_data.delete();
        m_wen = 0; m_err = 0; m_addr = 0; m_data = 0;
    endtask

    task automatic model_edge();
        bit          ready, full, ld_wr, wr, bad;
        int unsigned wrd;
        logic [31:0] wd;
        pend_t       p;
        ready = (skq_rd.size() == 0);
        full  = (ldq.size() == 2);
        ld_wr = 0; wr = 0; wrd = 0; wd = 0;
        if (mem_rvalid) begin
            if (ldq.size() == 0) m_err = 1;
            else begin
                p  = ldq.pop_front();
                wd = fmt(p.f3, p.off, mem_rdata, bad);
                if (bad) m_err = 1;
                wrd = p.rd; wr = 1; ld_wr = 1;
            end
        end
        if (!ld_wr && !ready) begin
            wr = 1; wrd = skq_rd.pop_front(); wd = skq_data.pop_front();
        end
        if (alu_valid && ready) begin
            if (ld_wr) begin skq_rd.push_back(alu_rd); skq_data.push_back(alu_data); end
            else begin wr = 1; wrd = alu_rd; wd = alu_data; end
        end
        if (ld_issue) begin
            if (full) m_err = 1;
            else ldq.push_back('{rd: ld_rd, f3: ld_funct3, off: ld_off});
        end
        m_wen = wr && (wrd != 0);
        if (m_wen) begin m_addr = 5'(wrd); m_data = wd; end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_issue = 0; ld_rd = 0; ld_funct3 = 0; ld_off = 0;
        mem_rvalid = 0; mem_rdata = 0;
    endtask

    // Called shortly after a rising edge with inputs already driven.
    task automatic cyc();
        #1;
        check("alu_ready", alu_ready, (skq_rd.size() == 0));
        check("ld_full", ld_full, (ldq.size() == 2));
        check("hazard", hazard, m_hazard());
        model_edge();
        @(posedge clock);
        #1;
        check("rf_wen", rf_wen, m_wen);
        check("err", err, m_err);
        if (m_wen) begin
            check("rf_rdaddr", rf_rdaddr, m_addr);
            check("rf_wdata", rf_wdata, m_data);
        end
`ifdef WB_FWD_EN
        check("fwd_rs1_hit", fwd_rs1_hit, m_wen && rs1_addr != 0 && rs1_addr == m_addr);
`endif
        idle();
    endtask

    task automatic do_reset();
        rstn = 0;
        #1;
        model_clear();
        check("rst_rf_wen", rf_wen, 1'b0);
        check("rst_rf_rdaddr", rf_rdaddr, 5'd0);
        check("rst_rf_wdata", rf_wdata, 32'd0);
        check("rst_err", err, 1'b0);
        check("rst_alu_ready", alu_ready, 1'b1);
        check("rst_ld_full", ld_full, 1'b0);
        check("rst_hazard", hazard, 1'b0);
        #1 rstn = 1;
    endtask

    task automatic issue(input int unsigned rd, input int unsigned f3, input int unsigned off);
        ld_issue = 1; ld_rd = 5'(rd); ld_funct3 = 3'(f3); ld_off = 2'(off);
    endtask

    task automatic respond(input logic [31:0] d);
        mem_rvalid = 1; mem_rdata = d;
    endtask

    task automatic alu(input int unsigned rd, input logic [31:0] d);
        alu_valid = 1; alu_rd = 5'(rd); alu_data = d;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        idle();
        rs1_addr = 0; rs2_addr = 0;
        model_clear();
        rstn = 0;
        repeat (2) @(posedge clock);
        #1;
        do_reset();

        // ALU write with one-cycle latency
        alu(5, 32'h1234); cyc();
        check("alu5_addr", rf_rdaddr, 5'd5);
        check("alu5_data", rf_wdata, 32'h1234);

        // LB / LBU at byte offset 2
        issue(7, 0, 2); cyc();
        respond(32'h0080_0000); cyc();
        check("lb_data", rf_wdata, 32'hFFFF_FF80);
        issue(7, 4, 2); cyc();
        respond(32'h0080_0000); cyc();
        check("lbu_data", rf_wdata, 32'h0000_0080);

        // load response and ALU result on the same edge
        issue(8, 2, 0); cyc();
        alu(3, 32'hAAAA_0003); respond(32'h5555_0008); cyc();
        check("coll_ld_addr", rf_rdaddr, 5'd8);
        check("coll_ready_low", alu_ready, 1'b0);
        cyc();
        check("coll_alu_addr", rf_rdaddr, 5'd3);

        // fill the queue, overflow, hazard until the second response
        rs1_addr = 10;
        issue(9, 2, 0); cyc();
        issue(10, 1, 2); cyc();
        check("full_set", ld_full, 1'b1);
        issue(11, 2, 0); cyc();
        check("ovf_err", err, 1'b1);
        respond(32'h1111_2222); cyc();
        respond(32'h8001_0000); cyc();
        cyc();
        check("hz_clear", hazard, 1'b0);
        rs1_addr = 0;

        // x0 ALU result never writes
        do_reset();
        alu(0, 32'hDEAD_BEEF); cyc();
        check("x0_no_wen", rf_wen, 1'b0);

        // reset with two loads in flight
        rs1_addr = 12; rs2_addr = 13;
        issue(12, 2, 0); cyc();
        issue(13, 2, 0); cyc();
        check("pend_hazard", hazard, 1'b1);
        do_reset();
        respond(32'h0); cyc();
        check("stale_resp_err", err, 1'b1);

        // randomized traffic with periodic resets
        for (int n = 0; n < 600; n++) begin
            if (n % 60 == 59) do_reset();
            rs1_addr = 5'($urandom_range(0, 12));
            rs2_addr = 5'($urandom_range(0, 12));
            if ($urandom_range(0, 1) == 1) alu($urandom_range(0, 12), $urandom);
            if ($urandom_range(0, 2) == 0)
                issue($urandom_range(0, 12),
                      ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7)
                                                  : (($urandom_range(0, 4) > 2) ? $urandom_range(4, 5)
                                                                                : $urandom_range(0, 2)),
                      $urandom_range(0, 3));
            if ($urandom_range(0, 9) < 4) respond($urandom);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have ports (name direction width meaning), clock and reset first: clock in 1 sole clock, rising edge; rstn in 1 asynchronous active-low reset.
REQ-002 SHALL have ALU result port: alu_valid in 1; alu_ready out 1; alu_rd in 5; alu_data in 32.
REQ-003 SHALL have load-issue port: ld_issue in 1 load sent to memory; ld_rd in 5; ld_funct3 in 3; ld_off in 2 byte offset; ld_full out 1 pending queue full.
REQ-004 SHALL have memory response port: mem_rvalid in 1; mem_rdata in 32; responses return in issue order.
REQ-005 SHALL have register-file write port: rf_wen out 1; rf_rdaddr out 5; rf_wdata out 32.
REQ-006 SHALL have hazard query: rs1_addr in 5; rs2_addr in 5; hazard out 1; err out 1 sticky protocol error.

Function
REQ-007 SHALL hold pending loads in a 2-entry in-order queue of {rd, funct3, off}; ld_full = count==2.
REQ-008 SHALL push on ld_issue && !ld_full, pop on mem_rvalid && count!=0; simultaneous push/pop keeps count; push when full is dropped and sets err.
REQ-009 SHALL ignore mem_rvalid with empty queue and set err.
REQ-010 SHALL register all rf_* outputs: an event sampled at edge N appears on rf_* during cycle N+1 (one-cycle latency).
REQ-011 SHALL give load responses priority over ALU results for the single write slot.
REQ-012 SHALL accept an ALU result on alu_valid && alu_ready; alu_ready = skid buffer empty.
REQ-013 SHALL write an accepted ALU result next cycle if no load response is sampled in the same cycle, else store it in a 1-entry skid buffer.
REQ-014 SHALL drain the skid buffer in the first cycle with no load response; drain and new acceptance in the same cycle are impossible (alu_ready low).
REQ-015 SHALL format load data: shifted = mem_rdata >> 8*off; 000 LB sign-extend byte, 001 LH sign-extend half, 010 LW, 100 LBU, 101 LHU zero-extend.
REQ-016 SHALL treat funct3 011/110/111 as LW and set err; LH/LHU with off[0]=1 or LW with off!=0 SHALL set err and still write formatted data.
REQ-017 SHALL never assert rf_wen for rd=0; such results are consumed silently.
REQ-018 SHALL assert hazard combinationally when rs1_addr or rs2_addr (nonzero) equals rd of any valid queue entry or of the valid skid entry.

Reset
REQ-019 SHALL, on rstn low at any time, asynchronously clear queue, skid, err, rf_wen=0, rf_rdaddr=0, rf_wdata=0; outputs after reset: alu_ready=1, ld_full=0, hazard=0.
REQ-020 SHALL discard in-flight loads on reset mid-operation; responses arriving after reset set err.

Configuration
REQ-021 SHALL, with WB_FWD_EN defined, add outputs fwd_rs1_hit and fwd_rs2_hit (1 each), high when rf_wen && rf_rdaddr equals the respective nonzero rs address; consumer takes rf_wdata.
REQ-022 SHALL, without WB_FWD_EN, omit those ports and extend hazard to include rf_wen && rf_rdaddr match.

Structure
REQ-023 SHALL take funct3 load-encoding constants and queue depth (2) from the shared core package.
REQ-024 SHALL implement load formatting as sub-module wb_load_fmt (pure combinational: funct3, off, rdata -> data, misalign).

Verification
REQ-025 ALU rd=5 data 0x1234 accepted at edge N -> rf_wen=1, rf_rdaddr=5, rf_wdata=0x1234 in cycle N+1.
REQ-026 LB off=2 rd=7, mem_rdata=0x0080_0000 -> rf_wdata=0xFFFF_FF80 to rd 7; LBU same -> 0x0000_0080.
REQ-027 ALU rd=3 and mem_rvalid same edge -> load written N+1, ALU 3 written N+2, alu_ready low during N+1.
REQ-028 Two ld_issue rd=9,10 -> ld_full=1; third issue -> err=1; rs1_addr=10 -> hazard=1 until second response.
REQ-029 ALU rd=0 -> no rf_wen; rstn low with 2 pending loads -> ld_full=0, hazard=0, following mem_rvalid sets err.
